gpu_blitter: RTL and testbench

GPU_BLITTER -- requirements
Module: gpu_blitter

---
 rtl/gpu_blitter.sv | 166 ++++++++++++++++
 tb/tb_gpu_blitter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_blitter.sv
// rtl/gpu_blitter.sv - 2D blit/fill engine with screen clipping, source flip and a
// one-outstanding-read memory port.
module gpu_blitter #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240,
  parameter int COORD_W   = 11,
  localparam int FXW = $clog2(FB_WIDTH),
  localparam int FYW = $clog2(FB_HEIGHT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [31:0]        cmd_src_addr,
  input  logic [15:0]        cmd_src_stride,
  input  logic [COORD_W-1:0] cmd_width,
  input  logic [COORD_W-1:0] cmd_height,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic               cmd_flip_x,
  input  logic               cmd_flip_y,
  input  logic [15:0]        cmd_color,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [15:0]        mem_rdata,
  output logic               fb_write,
  output logic [FXW-1:0]     fb_x,
  output logic [FYW-1:0]     fb_y,
  output logic [15:0]        fb_color,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, BLIT_REQ, BLIT_WAIT, FILL, DONE} state_t;

  localparam logic [COORD_W:0]   X_LIM = (COORD_W+1)'(FB_WIDTH);
  localparam logic [COORD_W:0]   Y_LIM = (COORD_W+1)'(FB_HEIGHT);
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

  state_t state, next_state;

  logic [31:0]        src_q;
  logic [15:0]        stride_q;
  logic [COORD_W-1:0] w_q, h_q, x_q, y_q;
  logic               fx_q, fy_q;
  logic [15:0]        color_q;
  logic [COORD_W-1:0] i_q, j_q;

  logic [COORD_W:0]   sx, sy;
  logic               visible, last_col, last_pix;
  logic [COORD_W-1:0] col, row;
  logic               advance, emit;
  logic [15:0]        emit_color;

  // Sign-extend the position one bit so that x+i can never alias into the visible range.
  assign sx       = {x_q[COORD_W-1], x_q} + {1'b0, i_q};
  assign sy       = {y_q[COORD_W-1], y_q} + {1'b0, j_q};
  assign visible  = !sx[COORD_W] && !sy[COORD_W] && (sx < X_LIM) && (sy < Y_LIM);
  assign last_col = (i_q == w_q - ONE);
  assign last_pix = last_col && (j_q == h_q - ONE);

  assign col      = fx_q ? (w_q - ONE - i_q) : i_q;
  assign row      = fy_q ? (h_q - ONE - j_q) : j_q;
  assign mem_addr = src_q + ((32'(row) * 32'(stride_q) + 32'(col)) << 1);

  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    mem_req    = 1'b0;
    advance    = 1'b0;
    emit       = 1'b0;
    emit_color = color_q;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_width == '0 || cmd_height == '0 || cmd_op[1]) next_state = DONE;
          else if (cmd_op[0])                                 next_state = FILL;
          else                                                next_state = BLIT_REQ;
        end
      end
      BLIT_REQ: begin
        if (!visible) begin
          advance = 1'b1;
          if (last_pix) next_state = DONE;
        end else begin
          mem_req = 1'b1;
          if (mem_gnt) next_state = BLIT_WAIT;
        end
      end
      BLIT_WAIT: begin
        if (mem_rvalid) begin
          advance    = 1'b1;
          emit       = mem_rdata[0];
          emit_color = mem_rdata;
          next_state = last_pix ? DONE : BLIT_REQ;
        end
      end
      FILL: begin
        advance = 1'b1;
        emit    = visible;
        if (last_pix) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= '0;
      stride_q <= '0;
      w_q      <= '0;
      h_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fx_q     <= 1'b0;
      fy_q     <= 1'b0;
      color_q  <= '0;
      i_q      <= '0;
      j_q      <= '0;
      fb_write <= 1'b0;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        src_q    <= cmd_src_addr;
        stride_q <= cmd_src_stride;
        w_q      <= cmd_width;
        h_q      <= cmd_height;
        x_q      <= cmd_x;
        y_q      <= cmd_y;
        fx_q     <= cmd_flip_x;
        fy_q     <= cmd_flip_y;
        color_q  <= cmd_color;
        i_q      <= '0;
        j_q      <= '0;
      end else if (advance) begin
        if (last_col) begin
          i_q <= '0;
          j_q <= j_q + ONE;
        end else begin
          i_q <= i_q + ONE;
        end
      end
      // Only visible pixels reach emit, so the truncated coordinates stay inside the framebuffer.
      fb_write <= emit;
      if (emit) begin
        fb_x     <= sx[FXW-1:0];
        fb_y     <= sy[FYW-1:0];
        fb_color <= emit_color;
      end
    end
  end

endmodule

// File: tb/tb_gpu_blitter.sv
// tb/tb_gpu_blitter.sv - table-driven and randomized bench for gpu_blitter against a
// per-pixel reference model and a latency-configurable memory model.
module tb_gpu_blitter;
  localparam int FBW = 400;
  localparam int FBH = 240;
  localparam int CW  = 11;

  logic          clk = 1'b0;
  logic          reset, cmd_valid, cmd_ready, cmd_flip_x, cmd_flip_y;
  logic [1:0]    cmd_op;
  logic [31:0]   cmd_src_addr, mem_addr;
  logic [15:0]   cmd_src_stride, cmd_color, mem_rdata, fb_color;
  logic [CW-1:0] cmd_width, cmd_height, cmd_x, cmd_y;
  logic          mem_req, mem_gnt, mem_rvalid, fb_write, busy;
  logic [8:0]    fb_x;
  logic [7:0]    fb_y;

  gpu_blitter #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .COORD_W(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src_addr(cmd_src_addr), .cmd_src_stride(cmd_src_stride),
    .cmd_width(cmd_width), .cmd_height(cmd_height), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_flip_x(cmd_flip_x), .cmd_flip_y(cmd_flip_y), .cmd_color(cmd_color),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fb_write(fb_write), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op; logic [31:0] src; int stride, w, h, x, y; bit fx, fy; logic [15:0] color;
    int mode, gnt_lat, rv_lat, exp_wr, exp_rd, exp_span;
  } vec_t;
  typedef struct { int x, y; logic [15:0] c; int cyc; } wr_t;

  int passed = 0, total = 0;
  int cyc = 0, oob = 0, addr_unstable = 0;
  int gnt_lat = 1, rv_lat = 1, mode = 0, rd_idx = 0, rv_cnt = 0, req_age = 0;
  bit manual = 1'b0, pend = 1'b0;
  logic [31:0] pend_addr, req_addr;
  logic [31:0] obs_addr[$], exp_addr[$];
  wr_t obs_wr[$], exp_wr[$];
  vec_t tbl[$];

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] mem_data(int md, logic [31:0] a, int k);
    logic [31:0] h;
    case (md)
      0: return 16'h0003;
      1: return (k % 2 == 0) ? 16'h0001 : 16'h0000;
      default: begin h = a * 32'h9E37_79B1; return h[31:16]; end
    endcase
  endfunction

  function automatic vec_t mk(int op, logic [31:0] src, int stride, int w, int h, int x, int y,
                              bit fx, bit fy, logic [15:0] color, int md, int gl, int rl,
                              int ewr, int erd, int espan);
    vec_t v;
    v.op = op; v.src = src; v.stride = stride; v.w = w; v.h = h; v.x = x; v.y = y;
    v.fx = fx; v.fy = fy; v.color = color; v.mode = md; v.gnt_lat = gl; v.rv_lat = rl;
    v.exp_wr = ewr; v.exp_rd = erd; v.exp_span = espan;
    return v;
  endfunction

  // Memory: grant after gnt_lat request cycles, data rv_lat cycles later, plus stray
  // rvalid pulses whenever no read is outstanding.
  always @(negedge clk) begin
    if (!manual) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (pend) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_data(mode, pend_addr, rd_idx);
          rd_idx++;
          pend = 1'b0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = 16'hFFFF;
      end
      if (mem_req) begin
        req_age++;
        if (req_age == 1) req_addr = mem_addr;
        else if (mem_addr !== req_addr) addr_unstable++;
        if (req_age >= gnt_lat) begin
          mem_gnt = 1'b1;
          obs_addr.push_back(mem_addr);
          pend_addr = mem_addr;
          pend = 1'b1;
          rv_cnt = rv_lat;
          req_age = 0;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    wr_t w;
    if (fb_write) begin
      w.x = int'(fb_x); w.y = int'(fb_y); w.c = fb_color; w.cyc = cyc;
      obs_wr.push_back(w);
      if (int'(fb_x) >= FBW || int'(fb_y) >= FBH) oob++;
    end
  end

  task automatic build_exp(vec_t v);
    int k, sx, sy, c, r;
    logic [31:0] a;
    logic [15:0] d;
    wr_t w;
    exp_addr.delete();
    exp_wr.delete();
    k = 0;
    if (v.op >= 2) return;
    for (int j = 0; j < v.h; j++) begin
      for (int i = 0; i < v.w; i++) begin
        sx = v.x + i;
        sy = v.y + j;
        if (sx < 0 || sx >= FBW || sy < 0 || sy >= FBH) continue;
        w.x = sx; w.y = sy; w.cyc = 0;
        if (v.op == 1) begin
          w.c = v.color;
          exp_wr.push_back(w);
        end else begin
          c = v.fx ? v.w - 1 - i : i;
          r = v.fy ? v.h - 1 - j : j;
          a = v.src + 32'(2 * (r * v.stride + c));
          exp_addr.push_back(a);
          d = mem_data(v.mode, a, k);
          k++;
          if (d[0]) begin
            w.c = d;
            exp_wr.push_back(w);
          end
        end
      end
    end
  endtask

  task automatic run_cmd(vec_t v, string tag);
    int n, m;
    @(negedge clk);
    gnt_lat = v.gnt_lat; rv_lat = v.rv_lat; mode = v.mode; rd_idx = 0;
    obs_addr.delete(); obs_wr.delete(); addr_unstable = 0;
    build_exp(v);
    cmd_op = 2'(v.op); cmd_src_addr = v.src; cmd_src_stride = 16'(v.stride);
    cmd_width = CW'(v.w); cmd_height = CW'(v.h); cmd_x = CW'(v.x); cmd_y = CW'(v.y);
    cmd_flip_x = v.fx; cmd_flip_y = v.fy; cmd_color = v.color;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, " ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_src_addr = $urandom; cmd_src_stride = 16'($urandom);
    cmd_width = CW'($urandom); cmd_height = CW'($urandom);
    cmd_x = CW'($urandom); cmd_y = CW'($urandom); cmd_color = 16'($urandom);
    check({tag, " busy"}, busy, 1);
    n = 0;
    while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
    check({tag, " done"}, cmd_ready, 1);
    @(negedge clk);
    check({tag, " n_reads"}, obs_addr.size(), exp_addr.size());
    check({tag, " n_writes"}, obs_wr.size(), exp_wr.size());
    if (v.exp_rd >= 0) check({tag, " n_reads_tbl"}, obs_addr.size(), v.exp_rd);
    if (v.exp_wr >= 0) check({tag, " n_writes_tbl"}, obs_wr.size(), v.exp_wr);
    m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) check({tag, " addr"}, obs_addr[i], exp_addr[i]);
    m = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < m; i++)
      check({tag, " pixel"}, {obs_wr[i].x[15:0], obs_wr[i].y[15:0], obs_wr[i].c},
            {exp_wr[i].x[15:0], exp_wr[i].y[15:0], exp_wr[i].c});
    if (v.exp_span >= 0 && obs_wr.size() > 0)
      check({tag, " span"}, obs_wr[obs_wr.size()-1].cyc - obs_wr[0].cyc, v.exp_span);
    check({tag, " addr_stable"}, addr_unstable, 0);
  endtask

  initial begin
    vec_t v;
    int sel;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src_addr = '0; cmd_src_stride = '0;
    cmd_width = '0; cmd_height = '0; cmd_x = '0; cmd_y = '0; cmd_flip_x = 1'b0;
    cmd_flip_y = 1'b0; cmd_color = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset busy", busy, 0);
    check("reset mem_req", mem_req, 0);
    check("reset fb_write", fb_write, 0);
    check("reset fb_xyc", {fb_x, fb_y, fb_color}, 0);
    reset = 1'b0;

    tbl.push_back(mk(1, 0, 0, 4, 2, 0, 0, 0, 0, 16'h1235, 0, 1, 1, 8, 0, 7));
    tbl.push_back(mk(0, 32'h1000, 8, 2, 2, 0, 0, 0, 0, 0, 0, 3, 2, 4, 4, -1));
    tbl.push_back(mk(0, 32'h1000, 8, 2, 2, 0, 0, 1, 1, 0, 0, 3, 2, 4, 4, -1));
    tbl.push_back(mk(0, 32'h2000, 4, 3, 2, -1, 239, 0, 0, 0, 0, 2, 2, 2, 2, -1));
    tbl.push_back(mk(0, 32'h0300, 3, 4, 1, 10, 10, 0, 0, 0, 1, 1, 1, 2, 4, -1));
    tbl.push_back(mk(1, 0, 0, 0, 3, 5, 5, 0, 0, 16'hAAAA, 0, 1, 1, 0, 0, -1));
    tbl.push_back(mk(2, 32'h40, 2, 2, 2, 0, 0, 0, 0, 16'h5555, 0, 1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 32'h40, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 3, 2, 400, 0, 0, 0, 16'h0F0F, 0, 1, 1, 0, 0, -1));
    tbl.push_back(mk(1, 0, 0, 4, 2, 398, -1, 0, 0, 16'hBEEF, 0, 1, 1, 2, 0, 1));
    tbl.push_back(mk(1, 0, 0, 2047, 1, -1000, 0, 0, 0, 16'h7777, 0, 1, 1, 400, 0, 399));
    tbl.push_back(mk(0, 32'hFFFF_FFFE, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 3, 2, 2, -1));
    foreach (tbl[t]) run_cmd(tbl[t], $sformatf("tbl%0d", t));

    // Reset while a read is outstanding; its late rvalid must be dropped.
    @(negedge clk);
    manual = 1'b1; pend = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    obs_wr.delete();
    cmd_op = 2'd0; cmd_src_addr = 32'h0; cmd_src_stride = 16'd0; cmd_width = CW'(1);
    cmd_height = CW'(1); cmd_x = '0; cmd_y = '0; cmd_flip_x = 1'b0; cmd_flip_y = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_mid req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rst_mid wait", {busy, mem_req}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h0001;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst_mid ready", cmd_ready, 1);
    @(negedge clk);
    check("rst_mid no_write", obs_wr.size(), 0);
    req_age = 0; manual = 1'b0;

    for (int t = 0; t < 40; t++) begin
      v.op = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 3));
      v.src = $urandom; v.stride = $urandom_range(0, 20);
      v.w = $urandom_range(0, 6); v.h = $urandom_range(0, 5);
      sel = $urandom_range(0, 2);
      v.x = (sel == 0) ? int'($urandom_range(0, 8)) - 4 : (sel == 1) ? 392 + int'($urandom_range(0, 12)) : int'($urandom_range(100, 200));
      sel = $urandom_range(0, 2);
      v.y = (sel == 0) ? int'($urandom_range(0, 8)) - 4 : (sel == 1) ? 232 + int'($urandom_range(0, 12)) : int'($urandom_range(50, 150));
      v.fx = 1'($urandom); v.fy = 1'($urandom); v.color = 16'($urandom);
      v.mode = 2; v.gnt_lat = $urandom_range(1, 3); v.rv_lat = $urandom_range(1, 3);
      v.exp_wr = -1; v.exp_rd = -1; v.exp_span = -1;
      run_cmd(v, $sformatf("rnd%0d", t));
    end

    check("fb bounds", oob, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
